port_sched_2x48: RTL
====================

PORT_SCHED_2X48 -- requirements
Module: port_sched_2x48

Interface
REQ-001 SHALL have parameter CREDITS, default 4: downstream buffer depth, i.e. initial and maximum credit count (legal 1..15).
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports a_valid, input, 1 / a_data, input, 48 / a_tail, input, 1: requester A flit, valid flag and last-flit-of-packet flag.
REQ-005 SHALL have ports b_valid, input, 1 / b_data, input, 48 / b_tail, input, 1: requester B, same meaning.
REQ-006 SHALL have ports a_ack, output, 1 and b_ack, output, 1: combinational pulse marking the presented flit consumed this cycle.
REQ-007 SHALL have port credit_in, input, 1: one-cycle pulse, one downstream buffer slot freed.
REQ-008 SHALL have ports out_valid, output, 1 / out_data, output, 48 / out_tail, output, 1: registered flit toward the downstream link.
REQ-009 SHALL have port sel, output, 1: current datapath select (0 = A, 1 = B).
REQ-010 SHALL have port busy, output, 1: high while a packet is locked (state LOCK_A or LOCK_B).
REQ-011 SHALL have port credit_err, output, 1: sticky credit-overflow flag.

Function
REQ-012 SHALL implement the flit path with the existing 48-bit 2:1 mux primitive driven by sel (and a 1-bit equivalent for tail); no other data transformation.
REQ-013 SHALL use FSM states IDLE, LOCK_A, LOCK_B.
REQ-014 Transfer condition: granted requester valid AND credit count > 0; no transfer when credits = 0.
REQ-015 In IDLE: if exactly one requester valid, grant it; if both valid, grant the one not equal to last_grant; if none valid, sel holds previous value.
REQ-016 In IDLE a grant with transfer occurs in the same cycle as the decision; if credits = 0, no grant is made and state stays IDLE.
REQ-017 On IDLE transfer with tail = 0: go to LOCK_A/LOCK_B per grant; with tail = 1 (single-flit packet): stay IDLE.
REQ-018 In LOCK_x: sel fixed to x; other requester ignored even if valid; transfer per REQ-014; return to IDLE on transfer of a flit with tail = 1.
REQ-019 last_grant SHALL update to the granted requester on the cycle its tail flit transfers.
REQ-020 x_ack SHALL equal (transfer this cycle AND granted = x); never both high.
REQ-021 out_valid/out_data/out_tail SHALL register the muxed flit one cycle after transfer (latency 1); out_valid = 0 in cycles following no transfer; out_data holds last value when out_valid = 0.
REQ-022 Credit counter: width 4; transfer only -> -1; credit_in only -> +1; both -> unchanged.
REQ-023 credit_in with counter = CREDITS and no simultaneous transfer -> counter saturates at CREDITS and credit_err sets; credit_err clears only on reset.
REQ-024 Back-to-back transfers every cycle SHALL be sustained while credits > 0 and valid held.

Reset
REQ-025 On reset: state IDLE, credits = CREDITS, last_grant = B (so A wins first tie), sel = 0, out_valid = 0, out_data = 0, out_tail = 0, credit_err = 0, busy = 0.
REQ-026 Reset asserted mid-packet SHALL abandon the lock; no tail emitted; next cycle behaves per REQ-025.
REQ-027 x_ack SHALL be 0 during any cycle with reset high.

Verification
REQ-028 Both valid from reset, 1-flit packets each, credits 4 -> grants A,B,A,B alternate; out_valid every cycle from cycle 2; credits reach 0 after 4 flits and stall.
REQ-029 A sends 3-flit packet (tail on flit 3), B valid throughout -> out shows A0,A1,A2 then B flit; b_ack 0 until A tail accepted; busy high 2 cycles.
REQ-030 CREDITS=2, no credit_in, A sends 4 flits -> 2 transfers, then a_ack 0; credit_in pulse -> exactly one more transfer next cycle.
REQ-031 Transfer and credit_in same cycle with credits = 1 -> credits stays 1; credit_in at credits = CREDITS idle -> credit_err = 1, stays 1 until reset.
REQ-032 Reset pulse while in LOCK_B after 1 of 3 flits -> state IDLE, credits = CREDITS, out_valid 0; with A and B valid afterwards A is granted.

Source files
------------

// File: rtl/port_sched_2x48.sv
// Two-requester packet scheduler onto one credit-controlled 48-bit link.
// Packets are locked until their tail flit and ties alternate on last_grant.
module port_sched_2x48 #(
    parameter int unsigned CREDITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [47:0] a_data,
    input  logic        a_tail,
    input  logic        b_valid,
    input  logic [47:0] b_data,
    input  logic        b_tail,
    output logic        a_ack,
    output logic        b_ack,
    input  logic        credit_in,
    output logic        out_valid,
    output logic [47:0] out_data,
    output logic        out_tail,
    output logic        sel,
    output logic        busy,
    output logic        credit_err
);

    localparam int unsigned DW = 48;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] credits;
    logic          last_grant;
    logic          sel_q;
    logic          gnt_b;
    logic          xfer;
    logic          cred_ok;
    logic [DW-1:0] mux_data;
    logic          mux_tail;

    // 2:1 flit mux primitive, select 0 = A, 1 = B
    function automatic logic [DW-1:0] mux2_48(input logic s, input logic [DW-1:0] d0,
                                              input logic [DW-1:0] d1);
        return s ? d1 : d0;
    endfunction

    assign cred_ok = (credits != '0);

    // Grant and transfer decision for the current cycle
    always_comb begin
        gnt_b = sel_q;
        xfer  = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) gnt_b = ~last_grant;
                else if (a_valid)       gnt_b = 1'b0;
                else if (b_valid)       gnt_b = 1'b1;
                xfer = (a_valid || b_valid) && cred_ok;
            end
            LOCK_A: begin
                gnt_b = 1'b0;
                xfer  = a_valid && cred_ok;
            end
            LOCK_B: begin
                gnt_b = 1'b1;
                xfer  = b_valid && cred_ok;
            end
            default: begin
                gnt_b = sel_q;
                xfer  = 1'b0;
            end
        endcase
    end

    // An idle cycle without a grant keeps the previous select
    assign sel      = (state == IDLE && !xfer) ? sel_q : gnt_b;
    assign mux_data = mux2_48(sel, a_data, b_data);
    assign mux_tail = sel ? b_tail : a_tail;

    assign a_ack = xfer && !gnt_b && !reset;
    assign b_ack = xfer &&  gnt_b && !reset;
    assign busy  = (state == LOCK_A) || (state == LOCK_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            credits    <= CRED_MAX;
            last_grant <= 1'b1;
            sel_q      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tail   <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            sel_q     <= sel;
            out_valid <= xfer;
            if (xfer) begin
                out_data <= mux_data;
                out_tail <= mux_tail;
            end

            case (state)
                IDLE: begin
                    if (xfer && !mux_tail) state <= gnt_b ? LOCK_B : LOCK_A;
                end
                LOCK_A, LOCK_B: begin
                    if (xfer && mux_tail) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (xfer && mux_tail) last_grant <= gnt_b;

            // Simultaneous consume and return cancel out
            case ({xfer, credit_in})
                2'b10: credits <= credits - 4'd1;
                2'b01: begin
                    if (credits >= CRED_MAX) credit_err <= 1'b1;
                    else                     credits    <= credits + 4'd1;
                end
                default: credits <= credits;
            endcase
        end
    end

endmodule
